// File: rtl/uart_pkg.sv
// Shared types and default sizing for the UART transmit scheduler.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;
    localparam int unsigned DEFAULT_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } uart_tx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick_c
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    assign tick_c = !clear && (count == CNT_MAX);

    // Wraps on every bit boundary so each state/bit restarts from zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || tick_c) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Two-requester round-robin UART transmitter (start, LSB-first data, optional even parity, stop).
// Define UART_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = DEFAULT_DATA_BITS
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req0_valid,
    input  logic [DATA_BITS-1:0] req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [DATA_BITS-1:0] req1_data,
    output logic                 req1_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 grant_id
);

    localparam int unsigned BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    uart_tx_state_t       state;
    uart_tx_state_t       state_nxt;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_nxt;
    logic [BIT_W-1:0]     bit_idx;
    logic                 last_grant;
    logic                 sel;
    logic                 accept;
    logic                 tick;
    logic                 tx_nxt;
    logic                 data_tick;
`ifdef UART_TX_PARITY_EN
    logic                 parity_bit;
`endif

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clock  (clock),
        .reset  (reset),
        .clear  (state == ST_IDLE),
        .tick_c (tick)
    );

    assign data_tick = (state == ST_DATA) && tick;

    // Round-robin arbiter: on a tie, the requester not granted last wins.
    always_comb begin
        sel = 1'b0;
        if (req0_valid && req1_valid) begin
            sel = ~last_grant;
        end else if (req1_valid) begin
            sel = 1'b1;
        end
        req0_ready = (state == ST_IDLE) && !reset && req0_valid && !sel;
        req1_ready = (state == ST_IDLE) && !reset && req1_valid && sel;
        accept     = req0_ready || req1_ready;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_START;
            ST_START: if (tick)   state_nxt = ST_DATA;
            ST_DATA: begin
                if (tick && (bit_idx == LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
                    state_nxt = ST_PARITY;
`else
                    state_nxt = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: if (tick) state_nxt = ST_STOP;
`endif
            ST_STOP:  if (tick)   state_nxt = ST_IDLE;
            default:              state_nxt = ST_IDLE;
        endcase
    end

    // Line level for the upcoming cycle, so tx leaves a flop.
    always_comb begin
        shift_nxt = shift_reg;
        if (accept) begin
            shift_nxt = sel ? req1_data : req0_data;
        end else if (data_tick) begin
            shift_nxt = shift_reg >> 1;
        end

        tx_nxt = 1'b1;
        case (state_nxt)
            ST_START:  tx_nxt = 1'b0;
            ST_DATA:   tx_nxt = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_nxt = parity_bit;
`endif
            default:   tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_reg  <= '0;
            bit_idx    <= '0;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
            tx         <= 1'b1;
            busy       <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            shift_reg <= shift_nxt;
            tx        <= tx_nxt;
            busy      <= (state_nxt != ST_IDLE);
            if (accept) begin
                grant_id   <= sel;
                last_grant <= sel;
                bit_idx    <= '0;
`ifdef UART_TX_PARITY_EN
                parity_bit <= ^shift_nxt;
`endif
            end else if (data_tick) begin
                bit_idx <= (bit_idx == LAST_BIT) ? '0 : bit_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed scoreboard bench for uart_tx_scheduler (CLKS_PER_BIT=4, DATA_BITS=8).
// Honours UART_TX_PARITY_EN for frame length and the parity bit.
module tb_uart_tx_scheduler;

    localparam int unsigned CPB = 4;
    localparam int unsigned DB  = 8;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned PAR = 1;
`else
    localparam int unsigned PAR = 0;
`endif
    localparam int unsigned NBITS     = DB + 2 + PAR;
    localparam int unsigned FRAME_LEN = NBITS * CPB;

    typedef struct packed {
        logic          grant;
        logic [DB-1:0] data;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req0_valid = 1'b0;
    logic [DB-1:0] req0_data  = '0;
    logic          req0_ready;
    logic          req1_valid = 1'b0;
    logic [DB-1:0] req1_data  = '0;
    logic          req1_ready;
    logic          tx;
    logic          busy;
    logic          grant_id;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    logic mon_en   = 1'b1;

    uart_tx_scheduler #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .tx         (tx),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Polls (from a negedge) until the requester's ready rises; reports elapsed cycles.
    task automatic wait_ready(input int idx, input string tag, output int cycles);
        logic r;
        cycles = 0;
        #1;
        r = (idx != 0) ? req1_ready : req0_ready;
        while (r !== 1'b1 && cycles < 3 * FRAME_LEN) begin
            @(negedge clock);
            #1;
            cycles++;
            r = (idx != 0) ? req1_ready : req0_ready;
        end
        chk(tag, 32'(r), 32'd1);
    endtask

    task automatic send0(input logic [DB-1:0] d, input string tag);
        int cyc;
        req0_data  = d;
        req0_valid = 1'b1;
        wait_ready(0, tag, cyc);
        @(negedge clock);
        req0_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while ((sb.size() != 0 || busy !== 1'b0) && n < 6 * FRAME_LEN) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    // Frame monitor: captures every frame on tx and compares it with the scoreboard head.
    initial begin : monitor
        exp_t             e;
        int               cyc;
        logic             first;
        logic             unstable;
        logic             g_moved;
        logic             g;
        logic [NBITS-1:0] obs_bits;
        logic [NBITS-1:0] exp_bits;
        forever begin
            @(negedge clock);
            if (mon_en && !reset && busy === 1'b1 && tx === 1'b0) begin
                g        = grant_id;
                cyc      = 0;
                first    = 1'b0;
                unstable = 1'b0;
                g_moved  = 1'b0;
                obs_bits = '0;
                while (busy === 1'b1 && cyc < 4 * FRAME_LEN) begin
                    if ((cyc / CPB) < NBITS) begin
                        if ((cyc % CPB) == 0) first = tx;
                        else if (tx !== first) unstable = 1'b1;
                        if ((cyc % CPB) == CPB / 2) obs_bits[cyc / CPB] = tx;
                    end
                    if (grant_id !== g) g_moved = 1'b1;
                    cyc++;
                    @(negedge clock);
                end
                chk("frame_len", 32'(cyc), 32'(FRAME_LEN));
                chk("bit_stable", 32'(unstable), 32'd0);
                chk("grant_hold", 32'(g_moved), 32'd0);
                chk("idle_tx_high", 32'(tx), 32'd1);
                chk("frame_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    exp_bits = '0;
                    exp_bits[NBITS-1] = 1'b1;
                    for (int i = 0; i < int'(DB); i++) exp_bits[1 + i] = e.data[i];
`ifdef UART_TX_PARITY_EN
                    exp_bits[DB + 1] = ^e.data;
`endif
                    chk("frame_bits", 32'(obs_bits), 32'(exp_bits));
                    chk("frame_grant", 32'(g), 32'(e.grant));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        int   cyc;
        logic busy_seen;

        // Reset state, with both requesters pending to prove ready is gated off.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Single frame 8'hA5 from requester 0.
        req0_data  = 8'hA5;
        req0_valid = 1'b1;
        #1;
        chk("a_ready0", 32'(req0_ready), 32'd1);
        chk("a_ready1", 32'(req1_ready), 32'd0);
        sb.push_back({1'b0, 8'hA5});
        @(negedge clock);
        #1;
        chk("a_ready_once", 32'(req0_ready), 32'd0);
        chk("a_busy", 32'(busy), 32'd1);
        chk("a_tx_fall", 32'(tx), 32'd0);
        req0_valid = 1'b0;
        wait_done("a_done");

        // Simultaneous requests after reset: 0 first, then 1 after one idle cycle.
        do_reset();
        req0_data  = 8'h11;
        req1_data  = 8'h22;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("b_ready0", 32'(req0_ready), 32'd1);
        chk("b_ready1", 32'(req1_ready), 32'd0);
        sb.push_back({1'b0, 8'h11});
        sb.push_back({1'b1, 8'h22});
        @(negedge clock);
        req0_valid = 1'b0;
        wait_ready(1, "b_ready1_late", cyc);
        chk("b_gap", 32'(cyc), 32'(FRAME_LEN));
        chk("b_gap_tx", 32'(tx), 32'd1);
        @(negedge clock);
        req1_valid = 1'b0;
        wait_done("b_done");
        chk("b_grant_hold_idle", 32'(grant_id), 32'd1);

        // Requester 1 held valid, requester 0 asks once: grants 0,1,1.
        do_reset();
        req0_data  = 8'h44;
        req1_data  = 8'h33;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("c_ready0", 32'(req0_ready), 32'd1);
        sb.push_back({1'b0, 8'h44});
        sb.push_back({1'b1, 8'h33});
        sb.push_back({1'b1, 8'h55});
        @(negedge clock);
        req0_valid = 1'b0;
        wait_ready(1, "c_ready1_a", cyc);
        @(negedge clock);
        req1_data = 8'h55;
        #1;
        chk("c_ready1_drop", 32'(req1_ready), 32'd0);
        wait_ready(1, "c_ready1_b", cyc);
        chk("c_gap2", 32'(cyc), 32'(FRAME_LEN));
        @(negedge clock);
        req1_valid = 1'b0;
        wait_done("c_done");

        // A one-cycle pulse on req1 while busy is ignored.
        send0(8'h66, "d_ready0");
        sb.push_back({1'b0, 8'h66});
        repeat (10) @(negedge clock);
        req1_data  = 8'h99;
        req1_valid = 1'b1;
        #1;
        chk("d_ready1", 32'(req1_ready), 32'd0);
        chk("d_ready0", 32'(req0_ready), 32'd0);
        chk("d_busy", 32'(busy), 32'd1);
        @(negedge clock);
        req1_valid = 1'b0;
        wait_done("d_done");
        busy_seen = 1'b0;
        repeat (2 * FRAME_LEN) begin
            @(negedge clock);
            if (busy !== 1'b0) busy_seen = 1'b1;
        end
        chk("d_no_frame", 32'(busy_seen), 32'd0);
        chk("d_grant", 32'(grant_id), 32'd0);

        // Reset in cycle 15 of a frame, then a clean frame.
        mon_en = 1'b0;
        send0(8'h77, "e_ready0");
        repeat (14) @(negedge clock);
        reset = 1'b1;
        #1;
        chk("e_tx", 32'(tx), 32'd1);
        chk("e_busy", 32'(busy), 32'd0);
        chk("e_grant", 32'(grant_id), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("e_idle_busy", 32'(busy), 32'd0);
        mon_en = 1'b1;
        send0(8'h88, "e_ready0_b");
        sb.push_back({1'b0, 8'h88});
        wait_done("e_done");

        // 8'h07: parity bit 1 when parity is built in.
        send0(8'h07, "f_ready0");
        sb.push_back({1'b0, 8'h07});
        wait_done("f_done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
